hs_src_fifo: RTL and testbench

HS_SRC_FIFO -- requirements
Module: hs_src_fifo

---
 rtl/hs_src_fifo_if.sv | 32 +++
 rtl/hs_src_fifo.sv | 122 ++++++++++++
 tb/tb_hs_src_fifo.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/hs_src_fifo_if.sv
// Producer/synchronizer signal bundle for hs_src_fifo; drop_cnt exists only with HS_SRC_DROP_CNT_EN.
// slave = the FIFO side, master = the producer plus handshake synchronizer side.
interface hs_src_fifo_if #(
   parameter int DW    = 8,
   parameter int DEPTH = 4
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic          wr_en;
   logic [DW-1:0] wr_data;
   logic          full;
   logic          empty;
   logic [LW-1:0] level;
   logic [DW-1:0] adata;
   logic          asend;
   logic          aready;
   logic          stall;

`ifdef HS_SRC_DROP_CNT_EN
   logic [7:0]    drop_cnt;

   modport slave  (input  wr_en, wr_data, aready,
                   output full, empty, level, adata, asend, stall, drop_cnt);
   modport master (output wr_en, wr_data, aready,
                   input  full, empty, level, adata, asend, stall, drop_cnt);
`else
   modport slave  (input  wr_en, wr_data, aready,
                   output full, empty, level, adata, asend, stall);
   modport master (output wr_en, wr_data, aready,
                   input  full, empty, level, adata, asend, stall);
`endif
endinterface

// File: rtl/hs_src_fifo.sv
// FIFO feeding a request/acknowledge synchronizer; write-to-asend latency 2 edges, full drops writes.
// Optional HS_SRC_DROP_CNT_EN adds a saturating drop_cnt; stall flags a SEND waiting 256 cycles.
module hs_src_fifo #(
   parameter int DEPTH = 4,
   parameter int DW    = 8
) (
   input logic          aclk,
   input logic          arst,
   hs_src_fifo_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

   state_t        state_q, state_d;
   logic          wait_first_q, wait_first_d;
   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [LW-1:0] level_q, level_d;
   logic [DW-1:0] adata_q, adata_d;
   logic [8:0]    scnt_q, scnt_d;
   logic          stall_q, stall_d;
   logic          full_w, empty_w, push, pop;

   always_comb begin
      full_w       = (level_q == LW'(DEPTH));
      empty_w      = (level_q == '0);
      push         = bus.wr_en && !full_w;
      pop          = 1'b0;
      state_d      = state_q;
      wait_first_d = wait_first_q;
      scnt_d       = scnt_q;
      case (state_q)
         IDLE: begin
            if (!empty_w) begin
               pop     = 1'b1;
               state_d = SEND;
               scnt_d  = '0;
            end
         end
         SEND: begin
            if (bus.aready) begin
               state_d      = WAIT;
               wait_first_d = 1'b1;
            end else if (scnt_q != 9'd256) begin
               scnt_d = scnt_q + 9'd1;
            end
         end
         WAIT: begin
            // aready may still be high from the acceptance, so the first WAIT cycle ignores it
            if (wait_first_q) begin
               wait_first_d = 1'b0;
            end else if (bus.aready) begin
               if (!empty_w) begin
                  pop     = 1'b1;
                  state_d = SEND;
                  scnt_d  = '0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      stall_d = stall_q | (scnt_d == 9'd256);
      adata_d = pop ? mem_q[rd_ptr_q] : adata_q;
      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (arst) begin
         state_q      <= IDLE;
         wait_first_q <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         adata_q      <= '0;
         scnt_q       <= '0;
         stall_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         wait_first_q <= wait_first_d;
         level_q      <= level_d;
         adata_q      <= adata_d;
         scnt_q       <= scnt_d;
         stall_q      <= stall_d;
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      end
   end

   // Storage needs no reset: the pointers and level define which entries are valid
   always_ff @(posedge aclk) begin
      if (!arst && push) mem_q[wr_ptr_q] <= bus.wr_data;
   end

   assign bus.full  = full_w;
   assign bus.empty = empty_w;
   assign bus.level = level_q;
   assign bus.adata = adata_q;
   assign bus.asend = (state_q == SEND);
   assign bus.stall = stall_q;

`ifdef HS_SRC_DROP_CNT_EN
   logic [7:0] drop_q;

   always_ff @(posedge aclk) begin
      if (arst) begin
         drop_q <= '0;
      end else if (bus.wr_en && full_w && drop_q != 8'hFF) begin
         drop_q <= drop_q + 8'd1;
      end
   end

   assign bus.drop_cnt = drop_q;
`endif
endmodule

// File: tb/tb_hs_src_fifo.sv
// Randomised and directed bench for hs_src_fifo against a queue-based reference model.
module tb_hs_src_fifo;
   localparam int DEPTH = 4;
   localparam int DW    = 8;

   logic aclk = 1'b0;
   logic arst;
   always #5 aclk = ~aclk;

   hs_src_fifo_if #(.DW(DW), .DEPTH(DEPTH)) bus ();
   hs_src_fifo #(.DEPTH(DEPTH), .DW(DW)) dut (.aclk(aclk), .arst(arst), .bus(bus));

   int n_vec = 0;
   int n_bad = 0;

   // Reference model: FIFO contents, words still owed downstream, output state
   int mq[$];
   int exp_out[$];
   int ms;        // 0 idle, 1 sending, 2 first cycle after accept, 3 waiting for round trip
   int madata;
   int mscnt;
   bit mstall;
   int mdrop;
   int gap;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input bit r, input bit w, input int wd, input bit ar);
      bit full_m;
      bit pop_m;
      arst        = r;
      bus.wr_en   = w;
      bus.wr_data = wd[7:0];
      bus.aready  = ar;
      if (!r && bus.asend === 1'b1 && ar) begin
         if (exp_out.size() > 0) chk("accept_order", {24'h0, bus.adata}, exp_out.pop_front());
         else                    chk("accept_extra", exp_out.size(), 1);
      end
      if (r) begin
         mq.delete(); exp_out.delete();
         ms = 0; madata = 0; mscnt = 0; mstall = 0; mdrop = 0;
      end else begin
         full_m = (mq.size() == DEPTH);
         pop_m  = 0;
         case (ms)
            0: if (mq.size() > 0) begin pop_m = 1; ms = 1; mscnt = 0; end
            1: begin
               if (ar) ms = 2;
               else if (mscnt < 256) begin
                  mscnt++;
                  if (mscnt == 256) mstall = 1;
               end
            end
            2: ms = 3;
            default: if (ar) begin
               if (mq.size() > 0) begin pop_m = 1; ms = 1; mscnt = 0; end
               else ms = 0;
            end
         endcase
         if (pop_m) madata = mq.pop_front();
         if (w && !full_m) begin
            mq.push_back(wd & 255);
            exp_out.push_back(wd & 255);
         end else if (w && mdrop < 255) begin
            mdrop++;
         end
      end
      @(posedge aclk);
      #1;
      chk("asend", bus.asend, ms == 1);
      chk("adata", bus.adata, madata);
      chk("level", bus.level, mq.size());
      chk("full",  bus.full,  mq.size() == DEPTH);
      chk("empty", bus.empty, mq.size() == 0);
      chk("stall", bus.stall, mstall);
`ifdef HS_SRC_DROP_CNT_EN
      chk("drop_cnt", bus.drop_cnt, mdrop);
`endif
   endtask

   // Synchronizer emulation: aready stays low for at least one cycle after each accept
   task automatic sync_cyc(input bit w, input int wd);
      bit ar;
      ar = (gap == 0) && ($urandom_range(0, 3) != 0);
      if (gap > 0) gap--;
      if (bus.asend === 1'b1 && ar) gap = 1 + $urandom_range(0, 2);
      cyc(0, w, wd, ar);
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget && exp_out.size() > 0; i++) sync_cyc(0, 0);
      chk("drain_left", exp_out.size(), 0);
   endtask

   initial begin
      int nw;
      arst = 1'b1; bus.wr_en = 1'b0; bus.wr_data = '0; bus.aready = 1'b0;
      gap = 0;

      cyc(1, 0, 0, 0);
      chk("rst_asend", bus.asend, 0);
      chk("rst_empty", bus.empty, 1);
      chk("rst_level", bus.level, 0);

      // Single word latency, then WAIT
      cyc(0, 1, 'h5A, 1);
      cyc(0, 0, 0, 1);
      chk("lat_asend", bus.asend, 1);
      chk("lat_adata", bus.adata, 'h5A);
      cyc(0, 0, 0, 1);
      chk("wait_asend", bus.asend, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 1);

      // Fill behind a word already in SEND, overflow, then drop during a pop
      cyc(1, 0, 0, 0);
      cyc(0, 1, 'hA0, 0);
      cyc(0, 1, 'h11, 0);
      cyc(0, 1, 'h22, 0);
      cyc(0, 1, 'h33, 0);
      cyc(0, 1, 'h44, 0);
      chk("fill_full",  bus.full, 1);
      chk("fill_level", bus.level, 4);
      cyc(0, 1, 'h55, 0);
      chk("ovf_level", bus.level, 4);
`ifdef HS_SRC_DROP_CNT_EN
      chk("ovf_drop", bus.drop_cnt, 1);
`endif
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 0);
      cyc(0, 1, 'h66, 1);
      chk("popdrop_level", bus.level, 3);
      chk("popdrop_adata", bus.adata, 'h11);
      gap = 1;
      drain(200);

      // Long stall in SEND
      cyc(1, 0, 0, 0);
      cyc(0, 1, 'h77, 0);
      cyc(0, 0, 0, 0);
      for (int i = 1; i <= 300; i++) begin
         cyc(0, 0, 0, 0);
         if (i == 255) chk("stall_255", bus.stall, 0);
         if (i == 256) chk("stall_256", bus.stall, 1);
      end
      cyc(0, 0, 0, 1);
      chk("stall_sticky", bus.stall, 1);
      chk("stall_adata",  bus.adata, 'h77);

      // Reset while in WAIT with two words queued; writes during reset ignored
      cyc(1, 0, 0, 0);
      cyc(0, 1, 'h01, 0);
      cyc(0, 1, 'h02, 0);
      cyc(0, 1, 'h03, 1);
      chk("pre_rst_level", bus.level, 2);
      cyc(1, 1, 'h99, 0);
      chk("mid_rst_asend", bus.asend, 0);
      chk("mid_rst_level", bus.level, 0);
      chk("mid_rst_empty", bus.empty, 1);
      for (int i = 0; i < 10; i++) begin
         cyc(0, 0, 0, 1);
         chk("no_stale", bus.asend, 0);
      end

      // Random traffic: 200 write attempts under random synchronizer timing
      cyc(1, 0, 0, 0);
      gap = 0;
      nw  = 0;
      while (nw < 200) begin
         if ($urandom_range(0, 1) == 1) begin
            sync_cyc(1, int'($urandom_range(0, 255)));
            nw++;
         end else begin
            sync_cyc(0, 0);
         end
      end
      drain(2000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
